console_matrix_scan: RTL and testbench
======================================

// Module: console_matrix_scan
// PURPOSE
//  Parametrised row-scan engine for the PiDP-10 front panel (successor to the fixed pidp10 scanner).
//  Time-multiplexes N LED rows and M switch rows over one row-address bus and one column bus.
//  Adds frame-coherent LED snapshot, PWM brightness and per-switch multi-frame debounce.
//  Sits between the console register file and the top-level column tristate pads.
// PARAMETERS
//  LED_ROWS      8   LED rows, row_addr 0..LED_ROWS-1
//  SW_ROWS       3   switch rows, row_addr LED_ROWS..LED_ROWS+SW_ROWS-1
//  COLS          18  column width
//  ROW_W         4   row_addr width; BLANK_ROW must fit
//  BLANK_ROW     15  row code selecting no row
//  SLOT_CYCLES   64  clk cycles per LED row slot (power of 2, >= 2**BRIGHT_W)
//  BLANK_CYCLES  4   dead time before every slot
//  SETTLE_CYCLES 8   switch-row cycles; sample on last
//  BRIGHT_W      3   brightness width
//  DEB_FRAMES    3   consecutive equal samples needed to accept a switch change (>=1)
// PORTS
//  clk         in   1                   system clock
//  reset_n     in   1                   asynchronous reset, active low
//  led_data    in   LED_ROWS*COLS       LED image, row r = bits [r*COLS +: COLS], 1 = lit
//  brightness  in   BRIGHT_W            global duty, sampled at frame start
//  row_addr    out  ROW_W               row select to panel decoder
//  col_out     out  COLS                column drive value
//  col_oe      out  1                   1 = top level drives col_out onto pads
//  col_in      in   COLS                pad readback; pulled up, closed switch reads 0
//  switches    out  SW_ROWS*COLS        debounced state, 1 = closed
//  sw_changed  out  1                   1-cycle pulse when any switches bit changes
//  frame_done  out  1                   1-cycle pulse on last cycle of a frame
// BEHAVIOUR
//  Reset (async assert, sync release): row_addr=BLANK_ROW, col_out=0, col_oe=0, switches=0,
//   sw_changed=0, frame_done=0, debounce counters=0, FSM=BLANK for row 0.
//  FSM states: BLANK, LED, SW. Slot index s walks 0..LED_ROWS+SW_ROWS-1 then wraps to 0.
//  BLANK: row_addr=BLANK_ROW, col_oe=1, col_out=0 for BLANK_CYCLES; then LED if s<LED_ROWS else SW.
//   Snapshot led_data and brightness on first BLANK cycle of s=0; image frozen for the frame.
//  LED: row_addr=s, col_oe=1 for SLOT_CYCLES. Slot cycle k (0-based): col_out=snap_row[s] when
//   k < (brightness+1)*SLOT_CYCLES>>BRIGHT_W, else 0. brightness=max -> full slot; 0 -> 1/2**BRIGHT_W.
//  SW: row_addr=s, col_oe=0, col_out=0 for SETTLE_CYCLES; on last cycle raw=~col_in for row s-LED_ROWS.
//  Debounce per bit: raw==switches -> count=0; else count++; when count reaches DEB_FRAMES,
//   switches bit <= raw, count=0. Applied at sample time; sw_changed asserted next cycle if any flip.
//  frame_done: last SW cycle of the final slot (SW_ROWS=0: last LED cycle). Frame length =
//   LED_ROWS*(BLANK_CYCLES+SLOT_CYCLES)+SW_ROWS*(BLANK_CYCLES+SETTLE_CYCLES) = 580 at defaults.
//  col_oe never 1 while row_addr selects a switch row; every row transition passes through BLANK.
//  led_data changes mid-frame: no effect until next frame. Reset mid-slot: immediate reset values.
//  Registered outputs only; no combinational path from inputs to outputs.
// STRUCTURE
//  Package console_pkg: typedef scan_state_e {BLANK,LED,SW}; BLANK_ROW default; frame-length function.
//  Sub-module switch_debounce (one instance per switch row, COLS wide, DEB_FRAMES counter per bit).
//  Tristate pad (inout col) stays at the top level, outside this block.
// TESTING
//  1 Reset: hold reset_n=0 -> row_addr=15, col_oe=0, switches=0; release -> first slot row_addr=0 after 4 cycles.
//  2 led_data row 2=18'h2AAAA, brightness=7 -> row_addr=2 for 64 cycles, col_out=2AAAA all 64; frame 580 cycles.
//  3 brightness=1 -> col_out=row data for first 16 cycles of each LED slot, 0 for remaining 48.
//  4 col_in bit 5 low on switch row 9 for 3 frames -> switches[1*18+5]=1, one sw_changed pulse; 2-frame glitch -> no change.
//  5 Change led_data mid-frame -> current frame shows old image, next frame new; check col_oe=0 whenever row_addr>=8 and <11.
//  6 Assert reset_n mid-LED slot -> outputs reset same cycle (async); debounced switches cleared.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and helpers for the console front-panel row scanner.
//   scan_state_e  : scan FSM state encoding
//   DEF_BLANK_ROW : row code that selects no panel row
//   frame_len()   : clk cycles in one full scan frame
package console_pkg;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_LED   = 2'd1,
      ST_SW    = 2'd2
   } scan_state_e;

   localparam int DEF_BLANK_ROW = 15;

   function automatic int frame_len(input int led_rows, input int sw_rows,
                                    input int slot_cycles, input int blank_cycles,
                                    input int settle_cycles);
      return led_rows * (blank_cycles + slot_cycles) + sw_rows * (blank_cycles + settle_cycles);
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Multi-frame debounce for one switch row.
//   clk, reset_n : clock, async active-low reset
//   sample       : 1 on the cycle this row is read (once per frame)
//   raw          : sampled switch value, 1 = closed
//   deb_state    : debounced switch value
//   flip         : combinational, 1 when this sample changes any debounced bit
// A bit follows raw only after DEB_FRAMES consecutive samples that disagree
// with the debounced value; any agreeing sample restarts the count.
module switch_debounce
   import console_pkg::*;
#(
   parameter int COLS       = 18,
   parameter int DEB_FRAMES = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sample,
   input  logic [COLS-1:0] raw,
   output logic [COLS-1:0] deb_state,
   output logic            flip
);

   localparam int CW = $clog2(DEB_FRAMES + 1);

   logic [CW-1:0]   cnt [COLS];
   logic [COLS-1:0] flip_bit;

   always_comb begin
      flip_bit = '0;
      for (int i = 0; i < COLS; i++) begin
         flip_bit[i] = (raw[i] != deb_state[i]) && (cnt[i] == CW'(DEB_FRAMES - 1));
      end
      flip = sample && (|flip_bit);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_state <= '0;
         for (int i = 0; i < COLS; i++) cnt[i] <= '0;
      end else if (sample) begin
         for (int i = 0; i < COLS; i++) begin
            if (raw[i] == deb_state[i]) begin
               cnt[i] <= '0;
            end else if (flip_bit[i]) begin
               cnt[i]       <= '0;
               deb_state[i] <= raw[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/console_matrix_scan.sv
// Row-scan engine for the PiDP-10 front panel. Time-multiplexes LED rows and
// switch rows over one row-address bus and one column bus, with a per-frame
// LED/brightness snapshot, PWM brightness and multi-frame switch debounce.
//   clk, reset_n : clock, async active-low reset
//   led_data     : LED image, row r = bits [r*COLS +: COLS]
//   brightness   : global duty, captured at frame start
//   row_addr     : panel row select (BLANK_ROW = none)
//   col_out      : column drive value
//   col_oe       : 1 = column pads driven
//   col_in       : pad readback, closed switch reads 0
//   switches     : debounced switch state, 1 = closed
//   sw_changed   : 1-cycle pulse on any debounced change
//   frame_done   : 1-cycle pulse on the last cycle of a frame
//
// state    | meaning
// ST_BLANK | dead time before slot `slot`, row deselected, columns driven low
// ST_LED   | LED row `slot` selected, columns driven with PWM-gated row data
// ST_SW    | switch row `slot` selected, columns released, sampled on last cycle
module console_matrix_scan
   import console_pkg::*;
#(
   parameter int LED_ROWS      = 8,
   parameter int SW_ROWS       = 3,
   parameter int COLS          = 18,
   parameter int ROW_W         = 4,
   parameter int BLANK_ROW     = DEF_BLANK_ROW,
   parameter int SLOT_CYCLES   = 64,
   parameter int BLANK_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int BRIGHT_W      = 3,
   parameter int DEB_FRAMES    = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [LED_ROWS*COLS-1:0] led_data,
   input  logic [BRIGHT_W-1:0]      brightness,
   output logic [ROW_W-1:0]         row_addr,
   output logic [COLS-1:0]          col_out,
   output logic                     col_oe,
   input  logic [COLS-1:0]          col_in,
   output logic [SW_ROWS*COLS-1:0]  switches,
   output logic                     sw_changed,
   output logic                     frame_done
);

   localparam int N_SLOTS = LED_ROWS + SW_ROWS;
   localparam int CNT_W   = $clog2(SLOT_CYCLES + BLANK_CYCLES + SETTLE_CYCLES + 1);
   localparam scan_state_e      LAST_STATE = (SW_ROWS == 0) ? ST_LED : ST_SW;
   localparam logic [ROW_W-1:0] LAST_SLOT  = ROW_W'(N_SLOTS - 1);

   // Position registers describe the cycle currently on the outputs; cnt is
   // the number of cycles left in the current state after this one. Reset
   // parks one extra cycle in BLANK so the reset cycle itself (col_oe=0) is
   // followed by a full BLANK_CYCLES of dead time.
   scan_state_e                state, state_nx;
   logic [ROW_W-1:0]           slot, slot_nx;
   logic [CNT_W-1:0]           cnt, cnt_nx;
   logic [LED_ROWS*COLS-1:0]   snap_img;
   logic [BRIGHT_W-1:0]        snap_bright;
   logic [CNT_W-1:0]           on_cycles;
   logic [COLS-1:0]            led_row;
   logic                       snap_take;
   logic                       sample;
   logic [SW_ROWS-1:0]         flip_vec;

   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      cnt_nx   = cnt - 1'b1;
      if (cnt == '0) begin
         case (state)
            ST_BLANK: begin
               if (slot < ROW_W'(LED_ROWS)) begin
                  state_nx = ST_LED;
                  cnt_nx   = CNT_W'(SLOT_CYCLES - 1);
               end else begin
                  state_nx = ST_SW;
                  cnt_nx   = CNT_W'(SETTLE_CYCLES - 1);
               end
            end
            default: begin
               state_nx = ST_BLANK;
               cnt_nx   = CNT_W'(BLANK_CYCLES - 1);
               slot_nx  = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end
         endcase
      end
   end

   // Lit window is the first on_cycles of the slot; with a down-counter that
   // is every cycle whose remaining count is at least SLOT_CYCLES-on_cycles.
   always_comb begin
      on_cycles = CNT_W'(((int'(snap_bright) + 1) * SLOT_CYCLES) >> BRIGHT_W);
      led_row   = '0;
      for (int r = 0; r < LED_ROWS; r++) begin
         if (slot_nx == ROW_W'(r)) led_row = snap_img[r*COLS +: COLS];
      end
      snap_take = (state_nx == ST_BLANK) && (slot_nx == '0) &&
                  (cnt_nx == CNT_W'(BLANK_CYCLES - 1));
      sample    = (state == ST_SW) && (cnt == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_BLANK;
         slot        <= '0;
         cnt         <= CNT_W'(BLANK_CYCLES);
         snap_img    <= '0;
         snap_bright <= '0;
         row_addr    <= ROW_W'(BLANK_ROW);
         col_out     <= '0;
         col_oe      <= 1'b0;
         frame_done  <= 1'b0;
         sw_changed  <= 1'b0;
      end else begin
         state      <= state_nx;
         slot       <= slot_nx;
         cnt        <= cnt_nx;
         row_addr   <= (state_nx == ST_BLANK) ? ROW_W'(BLANK_ROW) : slot_nx;
         col_oe     <= (state_nx != ST_SW);
         col_out    <= ((state_nx == ST_LED) && (cnt_nx >= CNT_W'(SLOT_CYCLES) - on_cycles))
                       ? led_row : '0;
         frame_done <= (state_nx == LAST_STATE) && (slot_nx == LAST_SLOT) && (cnt_nx == '0);
         sw_changed <= |flip_vec;
         if (snap_take) begin
            snap_img    <= led_data;
            snap_bright <= brightness;
         end
      end
   end

   for (genvar r = 0; r < SW_ROWS; r++) begin : g_sw
      switch_debounce #(
         .COLS       (COLS),
         .DEB_FRAMES (DEB_FRAMES)
      ) u_deb (
         .clk       (clk),
         .reset_n   (reset_n),
         .sample    (sample && (slot == ROW_W'(LED_ROWS + r))),
         .raw       (~col_in),
         .deb_state (switches[r*COLS +: COLS]),
         .flip      (flip_vec[r])
      );
   end

endmodule

// File: tb/tb_console_matrix_scan.sv
module tb_console_matrix_scan;
   import console_pkg::*;

   localparam int LR    = 8;
   localparam int SR    = 3;
   localparam int C     = 18;
   localparam int SLOT  = 64;
   localparam int NF    = 14;
   localparam int FRAME = 580;

   typedef struct {
      logic [3:0]  row;
      int          len;
      int          on;
      logic [17:0] data;
      bit          oe;
   } run_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [LR*C-1:0] led_data;
   logic [2:0]      brightness;
   logic [3:0]      row_addr;
   logic [C-1:0]    col_out;
   logic            col_oe;
   logic [C-1:0]    col_in;
   logic [SR*C-1:0] switches;
   logic            sw_changed;
   logic            frame_done;

   console_matrix_scan dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_data   (led_data),
      .brightness (brightness),
      .row_addr   (row_addr),
      .col_out    (col_out),
      .col_oe     (col_oe),
      .col_in     (col_in),
      .switches   (switches),
      .sw_changed (sw_changed),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // stimulus-side model state
   logic [17:0] img    [LR];
   logic [2:0]  bri;
   logic [17:0] closed [SR];
   logic [17:0] h1 [SR];
   logic [17:0] h2 [SR];
   logic [17:0] deb [SR];

   run_t        run_q [$];
   logic [53:0] sw_q  [$];
   int          fd_q  [$];

   // panel: pulled-up columns, closed switch on the selected switch row pulls low
   always_comb begin
      col_in = '1;
      for (int r = 0; r < SR; r++) begin
         if (int'(row_addr) == LR + r) col_in = ~closed[r];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, msg);
   endtask

   function automatic logic [53:0] pack_deb();
      logic [53:0] v;
      for (int r = 0; r < SR; r++) v[r*C +: C] = deb[r];
      return v;
   endfunction

   task automatic apply_img();
      for (int r = 0; r < LR; r++) led_data[r*C +: C] = img[r];
      brightness = bri;
   endtask

   // One frame of expected row activity, from the image visible at frame start.
   task automatic push_frame();
      run_t e;
      for (int s = 0; s < LR; s++) begin
         e = '{row: 4'd15, len: 4, on: 0, data: 18'd0, oe: 1'b1};
         run_q.push_back(e);
         e = '{row: 4'(s), len: SLOT, on: (int'(bri) + 1) * SLOT / 8, data: img[s], oe: 1'b1};
         run_q.push_back(e);
      end
      for (int r = 0; r < SR; r++) begin
         e = '{row: 4'd15, len: 4, on: 0, data: 18'd0, oe: 1'b1};
         run_q.push_back(e);
         e = '{row: 4'(LR + r), len: 8, on: 0, data: 18'd0, oe: 1'b0};
         run_q.push_back(e);
      end
      fd_q.push_back(cyc + FRAME - 1);
   endtask

   // Debounce model: a bit takes a new value once the last three frame
   // samples all agree with each other and disagree with the accepted value.
   task automatic model_switch_frame();
      logic [17:0] flip;
      for (int r = 0; r < SR; r++) begin
         flip  = (closed[r] ~^ h1[r]) & (closed[r] ~^ h2[r]) & (closed[r] ^ deb[r]);
         h2[r] = h1[r];
         h1[r] = closed[r];
         if (flip != '0) begin
            deb[r] = deb[r] ^ flip;
            sw_q.push_back(pack_deb());
         end
      end
   endtask

   // monitor
   logic [17:0] rc [$];
   bit          ro [$];
   logic [3:0]  rrow;
   bit          ract = 0;
   logic [53:0] prev_sw = '0;

   task automatic close_run();
      run_t        e;
      int          first_bad;
      logic [17:0] exp_col;
      ract = 0;
      if (run_q.size() == 0) begin
         fail("run_unexpected", $sformatf("row %0d len %0d with nothing expected", rrow, rc.size()));
         return;
      end
      e = run_q.pop_front();
      first_bad = -1;
      for (int k = 0; k < rc.size(); k++) begin
         exp_col = (e.on > k) ? e.data : 18'd0;
         if (first_bad < 0 && (rc[k] !== exp_col || ro[k] !== e.oe)) first_bad = k;
      end
      checks++;
      if (rrow !== e.row || rc.size() != e.len || first_bad >= 0) begin
         errors++;
         $display("FAIL run: got row %0d len %0d first_bad_cycle %0d, expected row %0d len %0d data %0h on %0d oe %0d",
                  rrow, rc.size(), first_bad, e.row, e.len, e.data, e.on, e.oe);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (ract && row_addr !== rrow) close_run();
         if (!ract) begin
            rrow = row_addr;
            rc.delete();
            ro.delete();
            ract = 1;
         end
         rc.push_back(col_out);
         ro.push_back(col_oe);

         if (sw_changed) begin
            if (sw_q.size() == 0) fail("sw_unexpected", $sformatf("pulse with switches %0h", switches));
            else chk("sw_pulse", 64'(switches), 64'(sw_q.pop_front()));
         end else if (switches !== prev_sw) begin
            fail("sw_no_pulse", $sformatf("switches %0h changed from %0h without pulse", switches, prev_sw));
         end
         prev_sw = switches;

         if (frame_done) begin
            if (fd_q.size() == 0) fail("frame_done_unexpected", $sformatf("pulse at cycle %0d", cyc));
            else chk("frame_done_cycle", 64'(cyc), 64'(fd_q.pop_front()));
         end
      end
   end

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: bench did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int x;
      reset_n  = 1'b0;
      led_data = '0;
      brightness = '0;
      for (int r = 0; r < SR; r++) begin
         closed[r] = '0; h1[r] = '0; h2[r] = '0; deb[r] = '0;
      end
      for (int r = 0; r < LR; r++) img[r] = 18'($urandom());
      img[2] = 18'h2AAAA;
      bri = 3'd7;
      apply_img();

      repeat (3) @(negedge clk);
      chk("reset_row_addr",   64'(row_addr),   64'd15);
      chk("reset_col_oe",     64'(col_oe),     64'd0);
      chk("reset_col_out",    64'(col_out),    64'd0);
      chk("reset_switches",   64'(switches),   64'd0);
      chk("reset_sw_changed", 64'(sw_changed), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);

      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      prev_sw = switches;
      mon_en  = 1;

      for (int f = 0; f < NF; f++) begin
         push_frame();
         repeat (150) @(posedge clk);
         #1;
         if (f < 6) begin
            for (int r = 0; r < SR; r++) closed[r] = '0;
            closed[1][5] = (f == 3 || f == 4) ? 1'b0 : 1'b1;
         end else begin
            for (int r = 0; r < SR; r++) begin
               if ($urandom_range(0, 2) == 0)
                  closed[r] = closed[r] ^ 18'($urandom() & $urandom() & $urandom());
            end
         end
         model_switch_frame();
         x = (f == 0) ? 200 : int'($urandom_range(1, 429));
         repeat (x) @(posedge clk);
         #1;
         for (int r = 0; r < LR; r++) img[r] = 18'($urandom());
         bri = (f == 0) ? 3'd1 : 3'($urandom_range(0, 7));
         apply_img();
         repeat (430 - x) @(posedge clk);
         #1;
      end

      @(negedge clk);
      #1;
      mon_en = 0;
      chk("run_queue_empty", 64'(run_q.size()), 64'd0);
      chk("sw_queue_empty",  64'(sw_q.size()),  64'd0);
      chk("fd_queue_empty",  64'(fd_q.size()),  64'd0);
      chk("switches_model",  64'(switches),     64'(pack_deb()));
      chk("switch_r1_b5",    64'(switches[1*C+5]), 64'(deb[1][5]));

      repeat (100) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midreset_row_addr",   64'(row_addr),   64'd15);
      chk("midreset_col_oe",     64'(col_oe),     64'd0);
      chk("midreset_col_out",    64'(col_out),    64'd0);
      chk("midreset_switches",   64'(switches),   64'd0);
      chk("midreset_sw_changed", 64'(sw_changed), 64'd0);
      chk("midreset_frame_done", 64'(frame_done), 64'd0);
      chk("frame_len_fn", 64'(frame_len(LR, SR, SLOT, 4, 8)), 64'(FRAME));

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
